traffic_light_controller: RTL and testbench

Sequences a two-way intersection (main road, side road) through green/yellow/all-red phases, using the one-cycle `tick` pulse from the clock divider as its time base. Main road rests on green and yields only after its minimum green when the side-road sensor or a latched pedestrian request is pending. A maintenance flash mode overrides normal sequencing. Sits between the clock divider and the lamp drivers.

---
 rtl/traffic_light_controller.sv | 192 +++++++++++++++++++
 tb/tb_traffic_light_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_controller
//  Description : Two-way intersection sequencer (main road / side road) with
//                minimum main green, pedestrian request latch and a
//                maintenance flash mode. Timed by a one-cycle tick pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_controller #(
   parameter int T_MAIN_MIN   = 30,
   parameter int T_SIDE_GREEN = 20,
   parameter int T_YELLOW     = 5,
   parameter int T_ALL_RED    = 2,
   parameter int TIMER_W      = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       side_req,
   input  logic       ped_req,
   input  logic       flash_en,
   output logic [2:0] main_light,
   output logic [2:0] side_light,
   output logic       walk,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_MAIN_GREEN  = 3'd0,
      ST_MAIN_YELLOW = 3'd1,
      ST_RED_TO_SIDE = 3'd2,
      ST_SIDE_GREEN  = 3'd3,
      ST_SIDE_YELLOW = 3'd4,
      ST_RED_TO_MAIN = 3'd5,
      ST_FLASH       = 3'd6,
      ST_ILLEGAL     = 3'd7
   } state_t;

   // Timer reload values: a phase of D ticks starts at D-1 and exits on the
   // tick that finds the timer at zero.
   localparam logic [TIMER_W-1:0] LOAD_MAIN    = TIMER_W'(T_MAIN_MIN - 1);
   localparam logic [TIMER_W-1:0] LOAD_SIDE    = TIMER_W'(T_SIDE_GREEN - 1);
   localparam logic [TIMER_W-1:0] LOAD_YELLOW  = TIMER_W'(T_YELLOW - 1);
   localparam logic [TIMER_W-1:0] LOAD_ALL_RED = TIMER_W'(T_ALL_RED - 1);
   localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

   // Lamp encodings, {red, yellow, green}
   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 ped_pending_q, ped_pending_d;
   logic                 flash_phase_q, flash_phase_d;
   logic [2:0]           main_d, side_d;
   logic                 walk_d;
   logic                 expire_w;
   logic                 count_w;

   assign expire_w = tick && (timer_q == '0);
   assign count_w  = tick && (timer_q != '0);
   assign state    = state_q;

   // Next-state, phase timer, pedestrian latch and flash phase
   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      ped_pending_d = ped_pending_q;
      flash_phase_d = flash_phase_q;

      if (ped_req && (state_q != ST_SIDE_GREEN)) begin
         ped_pending_d = 1'b1;
      end

      if (flash_en) begin
         // Flash overrides every tick-driven transition
         state_d = ST_FLASH;
         if (state_q != ST_FLASH) begin
            flash_phase_d = 1'b0;
         end else if (tick) begin
            flash_phase_d = ~flash_phase_q;
         end
      end else begin
         if (count_w) begin
            timer_d = timer_q - TIMER_ONE;
         end
         case (state_q)
            ST_MAIN_GREEN: begin
               // Rest on green with timer at zero until someone asks
               if (expire_w && (side_req || ped_pending_q)) begin
                  state_d = ST_MAIN_YELLOW;
                  timer_d = LOAD_YELLOW;
               end
            end
            ST_MAIN_YELLOW: begin
               if (expire_w) begin
                  state_d = ST_RED_TO_SIDE;
                  timer_d = LOAD_ALL_RED;
               end
            end
            ST_RED_TO_SIDE: begin
               if (expire_w) begin
                  state_d = ST_SIDE_GREEN;
                  timer_d = LOAD_SIDE;
               end
            end
            ST_SIDE_GREEN: begin
               if (expire_w) begin
                  state_d = ST_SIDE_YELLOW;
                  timer_d = LOAD_YELLOW;
               end
            end
            ST_SIDE_YELLOW: begin
               if (expire_w) begin
                  state_d = ST_RED_TO_MAIN;
                  timer_d = LOAD_ALL_RED;
               end
            end
            ST_RED_TO_MAIN: begin
               if (expire_w) begin
                  state_d = ST_MAIN_GREEN;
                  timer_d = LOAD_MAIN;
               end
            end
            ST_FLASH: begin
               // Leaving flash always clears through all-red
               state_d       = ST_RED_TO_MAIN;
               timer_d       = LOAD_ALL_RED;
               flash_phase_d = 1'b0;
            end
            default: begin
               state_d = ST_RED_TO_MAIN;
               timer_d = LOAD_ALL_RED;
            end
         endcase
      end

      // Serving the side phase satisfies the pedestrian; clear beats set
      if ((state_d == ST_SIDE_GREEN) && (state_q != ST_SIDE_GREEN)) begin
         ped_pending_d = 1'b0;
      end
   end

   // Lamp decode of the upcoming state so lamps change on the same edge
   always_comb begin
      main_d = LAMP_R;
      side_d = LAMP_R;
      walk_d = 1'b0;
      case (state_d)
         ST_MAIN_GREEN:  main_d = LAMP_G;
         ST_MAIN_YELLOW: main_d = LAMP_Y;
         ST_SIDE_GREEN: begin
            side_d = LAMP_G;
            walk_d = 1'b1;
         end
         ST_SIDE_YELLOW: side_d = LAMP_Y;
         ST_FLASH: begin
            main_d = flash_phase_d ? LAMP_Y : LAMP_OFF;
            side_d = flash_phase_d ? LAMP_R : LAMP_OFF;
         end
         default: begin
            main_d = LAMP_R;
            side_d = LAMP_R;
         end
      endcase
   end

   // State, timer, flags and registered lamp outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_RED_TO_MAIN;
         timer_q       <= LOAD_ALL_RED;
         ped_pending_q <= 1'b0;
         flash_phase_q <= 1'b0;
         main_light    <= LAMP_R;
         side_light    <= LAMP_R;
         walk          <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         ped_pending_q <= ped_pending_d;
         flash_phase_q <= flash_phase_d;
         main_light    <= main_d;
         side_light    <= side_d;
         walk          <= walk_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_controller
//  Description : Scoreboard bench for traffic_light_controller. A phase/
//                elapsed-tick reference model predicts each cycle's outputs;
//                a monitor pops and compares them after every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_controller;

   localparam int T_MAIN_MIN   = 4;
   localparam int T_SIDE_GREEN = 3;
   localparam int T_YELLOW     = 2;
   localparam int T_ALL_RED    = 1;
   localparam int TIMER_W      = 8;

   localparam logic [2:0] R   = 3'b100;
   localparam logic [2:0] Y   = 3'b010;
   localparam logic [2:0] G   = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0;
   logic       side_req = 1'b0;
   logic       ped_req = 1'b0;
   logic       flash_en = 1'b0;
   logic [2:0] main_light;
   logic [2:0] side_light;
   logic       walk;
   logic [2:0] state;

   traffic_light_controller #(
      .T_MAIN_MIN  (T_MAIN_MIN),
      .T_SIDE_GREEN(T_SIDE_GREEN),
      .T_YELLOW    (T_YELLOW),
      .T_ALL_RED   (T_ALL_RED),
      .TIMER_W     (TIMER_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .side_req  (side_req),
      .ped_req   (ped_req),
      .flash_en  (flash_en),
      .main_light(main_light),
      .side_light(side_light),
      .walk      (walk),
      .state     (state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic [2:0] m;
      logic [2:0] s;
      logic       w;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: phase number 0..6, ticks elapsed in the phase
   int   m_ph   = 5;
   int   m_n    = 0;
   bit   m_pend = 1'b0;
   bit   m_fph  = 1'b0;
   int   dur[6] = '{T_MAIN_MIN, T_YELLOW, T_ALL_RED, T_SIDE_GREEN, T_YELLOW, T_ALL_RED};

   task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.st = 3'(m_ph);
      e.w  = (m_ph == 3);
      case (m_ph)
         0:       begin e.m = G; e.s = R; end
         1:       begin e.m = Y; e.s = R; end
         3:       begin e.m = R; e.s = G; end
         4:       begin e.m = R; e.s = Y; end
         6:       begin e.m = m_fph ? Y : OFF; e.s = m_fph ? R : OFF; end
         default: begin e.m = R; e.s = R; end
      endcase
      return e;
   endfunction

   task automatic model_step(input bit r, input bit t, input bit sr, input bit pr, input bit fl);
      int old;
      bit new_pend;
      old = m_ph;
      if (!r) begin
         m_ph = 5; m_n = 0; m_pend = 1'b0; m_fph = 1'b0;
         return;
      end
      new_pend = m_pend | (pr && (old != 3));
      if (fl) begin
         if (old != 6) begin
            m_ph  = 6;
            m_fph = 1'b0;
         end else if (t) begin
            m_fph = ~m_fph;
         end
      end else if (old == 6) begin
         m_ph = 5; m_n = 0;
      end else if (t) begin
         m_n++;
         if (m_n >= dur[old]) begin
            if (old == 0 && !(sr || m_pend)) begin
               m_n = dur[0];
            end else begin
               m_ph = (old + 1) % 6;
               m_n  = 0;
            end
         end
      end
      if (m_ph == 3 && old != 3) new_pend = 1'b0;
      m_pend = new_pend;
   endtask

   task automatic step(input bit r, input bit t, input bit sr, input bit pr, input bit fl);
      @(negedge clk);
      reset_n  = r;
      tick     = t;
      side_req = sr;
      ped_req  = pr;
      flash_en = fl;
      model_step(r, t, sr, pr, fl);
      sb_q.push_back(model_out());
   endtask

   task automatic expect_state(input string nm, input logic [2:0] e);
      @(posedge clk);
      #1;
      chk(nm, state, e);
   endtask

   task automatic drive_to(input int ph, input bit sr);
      int k;
      k = 0;
      while (m_ph != ph && k < 200) begin
         step(1'b1, 1'b1, sr, 1'b0, 1'b0);
         k++;
      end
      if (k >= 200) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drive_to: phase %0d not reached, model at %0d", ph, m_ph);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest prediction each cycle
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("state", state, e.st);
            chk("main_light", main_light, e.m);
            chk("side_light", side_light, e.s);
            chk("walk", {2'b00, walk}, {2'b00, e.w});
            chk("dual_green", {2'b00, main_light[0] & side_light[0]}, 3'b000);
         end
      end
   end

   initial begin
      int  seq[14] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
      bit  fl, sr;

      // Reset, then fixed sequence with side_req held and tick every cycle
      repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      expect_state("reset_state", 3'd5);
      chk("reset_main", main_light, R);
      chk("reset_side", side_light, R);
      for (int i = 0; i < 14; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         expect_state("seq_state", 3'(seq[i]));
      end

      // No requests, tick every 4 cycles: rest on main green
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 60; c++) step(1'b1, (c % 4) == 3, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("rest_state", 3'd0);
      chk("rest_main", main_light, G);
      // Pedestrian pulse on a tick cycle, then let it be served
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 60; c++) step(1'b1, (c % 4) == 3, 1'b0, 1'b0, 1'b0);

      // Pedestrian pulse during side green is ignored
      drive_to(3, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 30; c++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_state("no_ped_latch", 3'd0);

      // Flash raised mid side green, dropped later
      drive_to(3, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_state("flash_entry", 3'd6);
      for (int c = 0; c < 12; c++) step(1'b1, (c % 2) == 1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("flash_exit", 3'd5);
      for (int c = 0; c < 6; c++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset mid main yellow with a pending pedestrian request
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      drive_to(1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 40; c++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_state("post_reset_rest", 3'd0);

      // Tick and flash together at main yellow expiry
      drive_to(1, 1'b1);
      for (int k = 0; k < 10 && m_n != dur[1] - 1; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      expect_state("flash_beats_tick", 3'd6);
      for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Randomized traffic
      fl = 1'b0;
      sr = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) == 0) fl = ~fl;
         if ($urandom_range(0, 19) == 0) sr = ~sr;
         step($urandom_range(0, 299) != 0, $urandom_range(0, 2) == 0, sr,
              $urandom_range(0, 39) == 0, fl);
      end

      repeat (3) @(negedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
